unidade_controle: RTL and testbench
===================================

Name: unidade_controle

Overview:
- Moore FSM that sequences the memory-game datapath one level below it.
- Consumes the datapath status flags: jogada_feita, jogada_correta, enderecoIgualRodada, fimCR, timeout.
- Produces every datapath clear, count, register and write strobe.
- Per round: replays the stored sequence 0..rodada against player inputs. After the last correct play, accepts one new play and writes it to RAM at the rodada address. Ends in win, error or timeout.

Parameters:
- TIMEOUT_EN, default 1. When 0, the timeout input is ignored in both wait states.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; forces state inicial
- iniciar  in  1  start/restart request, level-sampled
- jogada_feita  in  1  one-cycle pulse, new key press
- jogada_correta  in  1  registered play equals RAM data
- enderecoIgualRodada  in  1  address counter equals round counter
- fimCR  in  1  round counter at terminal count (15)
- timeout  in  1  timeout counter terminal count
- zeraR, registraR  out  1  play register clear / load
- zeraCR, contaCR  out  1  round counter clear / increment
- zeraCE, contaCE  out  1  address counter clear / increment
- zeraT, contaT  out  1  timeout counter clear / count
- grava  out  1  RAM write enable; also steers RAM address to rodada
- pronto, ganhou, perdeu, timeout_flag  out  1  end-of-game status
- db_estado  out  4  current state encoding

Behaviour:
- State register is 4 bits, updated on the rising clock edge.
- All outputs are decoded combinationally from state only (Moore). Each output is valid in the cycle the state is occupied.
- reset=1 → next state inicial, in any state including mid-round. In inicial all outputs are 0 and db_estado=0.
- State encodings, outputs asserted and transitions:
  - inicial (0): no outputs. iniciar=1 → preparacao.
  - preparacao (1): zeraCR, zeraCE, zeraR, zeraT. → inicio_rodada.
  - inicio_rodada (2): zeraCE, zeraT. → espera_jogada.
  - espera_jogada (3): contaT.
    - timeout & TIMEOUT_EN → fim_timeout.
    - else jogada_feita → registra.
    - else stay.
  - registra (4): registraR, zeraT. → comparacao.
  - comparacao (5): no outputs. Decisions in priority order:
    - !jogada_correta → fim_errou.
    - enderecoIgualRodada & fimCR → fim_acertou.
    - enderecoIgualRodada → espera_nova.
    - else → proximo.
  - proximo (6): contaCE. → espera_jogada.
  - espera_nova (7): contaT. Same timeout / jogada_feita priority as espera_jogada; jogada_feita → grava_jogada.
  - grava_jogada (8): grava for exactly one cycle. → proxima_rodada.
  - proxima_rodada (9): contaCR, zeraT. → inicio_rodada.
  - fim_acertou (10): pronto, ganhou.
  - fim_errou (11): pronto, perdeu.
  - fim_timeout (12): pronto, perdeu, timeout_flag.
  - All three end states hold until iniciar=1, then → preparacao.
- Encodings 13–15 are unreachable; if entered, → inicial next cycle with all outputs 0.
- iniciar is ignored in states 1–9.
- Timeout beats jogada_feita when both are high in the same cycle.
- Per-play latency from jogada_feita in espera_jogada to verdict:
  - jogada_feita at cycle n → registra at n+1, comparacao at n+2.
  - End state or proximo at n+3.
- Round wrap: fimCR at a correct last play ends the game as a win. contaCR is never issued at round 15, so the counter never wraps.
- grava and registraR are never asserted in the same state.
- contaCE and contaCR are never asserted in the same state.

Test Plan:
- Reset mid-game: reset=1 held one cycle while in espera_jogada → db_estado=0 next cycle; all outputs 0; iniciar=0 keeps state 0.
- Start: iniciar=1 one cycle from inicial → db_estado sequence 1,2,3; zeraCR/zeraCE/zeraR/zeraT high only in state 1.
- Round 0, correct play: jogada_feita with jogada_correta=1, enderecoIgualRodada=1, fimCR=0 → states 4,5,7.
  - Then jogada_feita → states 8,9,2.
  - grava high exactly 1 cycle; contaCR high exactly 1 cycle.
- Wrong play: in state 3 pulse jogada_feita with jogada_correta=0 → states 4,5,11; perdeu=1, pronto=1 held.
  - iniciar=1 → state 1.
- Timeout: hold timeout=1 in state 7 → state 12 with timeout_flag=1.
  - timeout and jogada_feita together in state 3 → state 12.
  - With TIMEOUT_EN=0: state stays 3, and jogada_feita → state 4.
- Win: comparacao with jogada_correta=1, enderecoIgualRodada=1, fimCR=1 → state 10; ganhou=1; contaCR never asserted.

Source files
------------

// File: rtl/unidade_controle.sv
// unidade_controle: Moore control unit for the memory-game datapath.
// Sequences each round: it replays the stored sequence against the player's
// presses, then stores one new play and advances the round. The game ends in
// a win, an error or a timeout, and holds there until a new start request.
`timescale 1ns/1ps

module unidade_controle #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimCR,
    input  logic       timeout,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraCR,
    output logic       contaCR,
    output logic       zeraCE,
    output logic       contaCE,
    output logic       zeraT,
    output logic       contaT,
    output logic       grava,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout_flag,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARACAO     = 4'd1,
        INICIO_RODADA  = 4'd2,
        ESPERA_JOGADA  = 4'd3,
        REGISTRA       = 4'd4,
        COMPARACAO     = 4'd5,
        PROXIMO        = 4'd6,
        ESPERA_NOVA    = 4'd7,
        GRAVA_JOGADA   = 4'd8,
        PROXIMA_RODADA = 4'd9,
        FIM_ACERTOU    = 4'd10,
        FIM_ERROU      = 4'd11,
        FIM_TIMEOUT    = 4'd12
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    // A timeout only counts when the feature is enabled at elaboration time.
    logic timeout_ativo;
    assign timeout_ativo = timeout & TIMEOUT_EN;

    // State register; reset returns to the idle state from anywhere, mid-round included.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; timeout is checked before a key press in both wait states.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (timeout_ativo) begin
                    estado_d = FIM_TIMEOUT;
                end else if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else begin
                    estado_d = ESPERA_JOGADA;
                end
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!jogada_correta) begin
                    estado_d = FIM_ERROU;
                end else if (enderecoIgualRodada && fimCR) begin
                    estado_d = FIM_ACERTOU;
                end else if (enderecoIgualRodada) begin
                    estado_d = ESPERA_NOVA;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:        estado_d = ESPERA_JOGADA;
            ESPERA_NOVA: begin
                if (timeout_ativo) begin
                    estado_d = FIM_TIMEOUT;
                end else if (jogada_feita) begin
                    estado_d = GRAVA_JOGADA;
                end else begin
                    estado_d = ESPERA_NOVA;
                end
            end
            GRAVA_JOGADA:   estado_d = PROXIMA_RODADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : estado_q;
            default:        estado_d = INICIAL;
        endcase
    end

    // Moore output decode; every strobe depends on the current state only.
    always_comb begin
        zeraR        = 1'b0;
        registraR    = 1'b0;
        zeraCR       = 1'b0;
        contaCR      = 1'b0;
        zeraCE       = 1'b0;
        contaCE      = 1'b0;
        zeraT        = 1'b0;
        contaT       = 1'b0;
        grava        = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        timeout_flag = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraCR = 1'b1;
                zeraCE = 1'b1;
                zeraR  = 1'b1;
                zeraT  = 1'b1;
            end
            INICIO_RODADA: begin
                zeraCE = 1'b1;
                zeraT  = 1'b1;
            end
            ESPERA_JOGADA:  contaT = 1'b1;
            REGISTRA: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            PROXIMO:        contaCE = 1'b1;
            ESPERA_NOVA:    contaT = 1'b1;
            GRAVA_JOGADA:   grava = 1'b1;
            PROXIMA_RODADA: begin
                contaCR = 1'b1;
                zeraT   = 1'b1;
            end
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto       = 1'b1;
                perdeu       = 1'b1;
                timeout_flag = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Testbench for unidade_controle: one instance with timeout enabled and one
// with it disabled share the same inputs; a game-level reference model
// predicts the state and the strobes of both after every clock edge.
`timescale 1ns/1ps

module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada_feita, jogada_correta;
    logic       enderecoIgualRodada, fimCR, timeout;

    logic       zeraR1, registraR1, zeraCR1, contaCR1, zeraCE1, contaCE1, zeraT1, contaT1;
    logic       grava1, pronto1, ganhou1, perdeu1, tflag1;
    logic [3:0] estado1;
    logic       zeraR0, registraR0, zeraCR0, contaCR0, zeraCE0, contaCE0, zeraT0, contaT0;
    logic       grava0, pronto0, ganhou0, perdeu0, tflag0;
    logic [3:0] estado0;

    int compared = 0;
    int mismatched = 0;

    // Reference model state (game phase numbers) for each instance.
    int m1, m0;
    // Datapath counters the bench keeps itself to derive the status flags.
    int rodada, endereco;

    always #5 clock = ~clock;

    unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .enderecoIgualRodada(enderecoIgualRodada), .fimCR(fimCR), .timeout(timeout),
        .zeraR(zeraR1), .registraR(registraR1), .zeraCR(zeraCR1), .contaCR(contaCR1),
        .zeraCE(zeraCE1), .contaCE(contaCE1), .zeraT(zeraT1), .contaT(contaT1),
        .grava(grava1), .pronto(pronto1), .ganhou(ganhou1), .perdeu(perdeu1),
        .timeout_flag(tflag1), .db_estado(estado1)
    );

    unidade_controle #(.TIMEOUT_EN(1'b0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .enderecoIgualRodada(enderecoIgualRodada), .fimCR(fimCR), .timeout(timeout),
        .zeraR(zeraR0), .registraR(registraR0), .zeraCR(zeraCR0), .contaCR(contaCR0),
        .zeraCE(zeraCE0), .contaCE(contaCE0), .zeraT(zeraT0), .contaT(contaT0),
        .grava(grava0), .pronto(pronto0), .ganhou(ganhou0), .perdeu(perdeu0),
        .timeout_flag(tflag0), .db_estado(estado0)
    );

    logic [12:0] outs1, outs0;
    assign outs1 = {zeraR1, registraR1, zeraCR1, contaCR1, zeraCE1, contaCE1, zeraT1,
                    contaT1, grava1, pronto1, ganhou1, perdeu1, tflag1};
    assign outs0 = {zeraR0, registraR0, zeraCR0, contaCR0, zeraCE0, contaCE0, zeraT0,
                    contaT0, grava0, pronto0, ganhou0, perdeu0, tflag0};

    // Game phases as listed in the state table.
    localparam int INICIAL = 0, PREPARACAO = 1, INICIO_RODADA = 2, ESPERA_JOGADA = 3;
    localparam int REGISTRA = 4, COMPARACAO = 5, PROXIMO = 6, ESPERA_NOVA = 7;
    localparam int GRAVA_JOGADA = 8, PROXIMA_RODADA = 9;
    localparam int FIM_ACERTOU = 10, FIM_ERROU = 11, FIM_TIMEOUT = 12;

    // Strobe table, bit order: zeraR registraR zeraCR contaCR zeraCE contaCE zeraT
    // contaT grava pronto ganhou perdeu timeout_flag.
    function automatic logic [12:0] expected_outs(input int s);
        logic [12:0] t [0:12];
        t[INICIAL]        = 13'b0000000000000;
        t[PREPARACAO]     = 13'b1010101000000;
        t[INICIO_RODADA]  = 13'b0000101000000;
        t[ESPERA_JOGADA]  = 13'b0000000100000;
        t[REGISTRA]       = 13'b0100001000000;
        t[COMPARACAO]     = 13'b0000000000000;
        t[PROXIMO]        = 13'b0000010000000;
        t[ESPERA_NOVA]    = 13'b0000000100000;
        t[GRAVA_JOGADA]   = 13'b0000000010000;
        t[PROXIMA_RODADA] = 13'b0001001000000;
        t[FIM_ACERTOU]    = 13'b0000000001100;
        t[FIM_ERROU]      = 13'b0000000001010;
        t[FIM_TIMEOUT]    = 13'b0000000001011;
        return t[s];
    endfunction

    // Game rules: where the phase goes next given this cycle's inputs.
    function automatic int next_phase(input int s, input logic rst, ini, jf, jc, eir,
                                      fcr, to, input bit ten);
        bit expired;
        expired = to && ten;
        if (rst) return INICIAL;
        if (s == INICIAL) return ini ? PREPARACAO : INICIAL;
        if (s >= FIM_ACERTOU) return ini ? PREPARACAO : s;
        if (s == ESPERA_JOGADA || s == ESPERA_NOVA) begin
            if (expired) return FIM_TIMEOUT;
            if (!jf) return s;
            return (s == ESPERA_JOGADA) ? REGISTRA : GRAVA_JOGADA;
        end
        if (s == COMPARACAO) begin
            if (!jc) return FIM_ERROU;
            if (!eir) return PROXIMO;
            return fcr ? FIM_ACERTOU : ESPERA_NOVA;
        end
        if (s == PROXIMO) return ESPERA_JOGADA;
        if (s == PROXIMA_RODADA) return INICIO_RODADA;
        return s + 1;
    endfunction

    task automatic check_all();
        compared++;
        assert (estado1 === 4'(m1)) else begin
            mismatched++;
            $error("FAIL estado_te1 observed=%0d expected=%0d", estado1, m1);
        end
        compared++;
        assert (outs1 === expected_outs(m1)) else begin
            mismatched++;
            $error("FAIL saidas_te1 observed=%b expected=%b", outs1, expected_outs(m1));
        end
        compared++;
        assert (estado0 === 4'(m0)) else begin
            mismatched++;
            $error("FAIL estado_te0 observed=%0d expected=%0d", estado0, m0);
        end
        compared++;
        assert (outs0 === expected_outs(m0)) else begin
            mismatched++;
            $error("FAIL saidas_te0 observed=%b expected=%b", outs0, expected_outs(m0));
        end
        compared++;
        assert ((grava1 & registraR1) === 1'b0 && (contaCE1 & contaCR1) === 1'b0) else begin
            mismatched++;
            $error("FAIL exclusao observed=%b%b%b%b expected=no overlap",
                   grava1, registraR1, contaCE1, contaCR1);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic tick(input logic rst, ini, jf, jc, eir, fcr, to);
        int n1, n0;
        reset = rst; iniciar = ini; jogada_feita = jf; jogada_correta = jc;
        enderecoIgualRodada = eir; fimCR = fcr; timeout = to;
        n1 = next_phase(m1, rst, ini, jf, jc, eir, fcr, to, 1'b1);
        n0 = next_phase(m0, rst, ini, jf, jc, eir, fcr, to, 1'b0);
        @(posedge clock);
        #1;
        m1 = n1;
        m0 = n0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        m1 = 0; m0 = 0; rodada = 0; endereco = 0;
        // Reset, then start and reach espera_jogada.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        // Reset mid-game, idle holds inicial.
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Round 0: correct play, then new play stored.
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        tick(0, 0, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 1, 0, 0);
        tick(0, 0, 1, 1, 1, 0, 0);
        idle(3);
        // Wrong play ends in fim_errou, held until iniciar.
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        // Timeout in espera_nova.
        tick(0, 0, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 0, 1);
        // Timeout together with a press in espera_jogada.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        tick(0, 0, 1, 1, 0, 0, 1);
        tick(0, 0, 0, 1, 1, 0, 1);
        idle(2);
        // Timeout held in espera_jogada, then a press.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0, 0, 1);
        tick(0, 0, 1, 1, 0, 0, 0);
        idle(2);
        // Win at the last round.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        tick(0, 0, 1, 1, 1, 1, 0);
        tick(0, 0, 0, 1, 1, 1, 0);
        tick(0, 0, 0, 1, 1, 1, 0);
        idle(3);
        tick(0, 1, 0, 0, 0, 0, 0);

        // Randomized games: flags come from bench-side counters following the
        // strobes the model expects for the timeout-enabled instance.
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            logic rst, ini, jf, jc, to, eir, fcr;
            logic [12:0] e;
            rst = ($urandom_range(0, 299) == 0);
            ini = ($urandom_range(0, 7) == 0);
            jf  = ($urandom_range(0, 2) == 0);
            jc  = ($urandom_range(0, 15) != 0);
            to  = ($urandom_range(0, 24) == 0);
            eir = (endereco == rodada);
            fcr = (rodada == 15);
            e = expected_outs(m1);
            if (e[10]) rodada = 0;
            else if (e[9]) rodada = rodada + 1;
            if (e[8]) endereco = 0;
            else if (e[7]) endereco = endereco + 1;
            tick(rst, ini, jf, jc, eir, fcr, to);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
